// File: rtl/bpm_test_tx_pkg.sv
// Shared types and default widths for the BPM test TX link arbiters.
// Index-width helper keeps single-source builds at a 1-bit index.
package bpm_test_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } txState_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int ABORT_CNT_WIDTH    = 16;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping cyclically to index 0.
module rr_priority_picker
  import bpm_test_tx_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = idxWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  // The upper pass wins; the lower pass only covers the wrap-around.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (IDX_W'(i) >= pointer)) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bpm_test_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the Aurora BPM test TX stream,
// with a per-FA-cycle packet budget and drain-on-channel-drop.
module bpm_test_tx_arbiter
  import bpm_test_tx_pkg::*;
#(
  parameter int NUM_SOURCES           = 2,
  parameter int DATA_WIDTH            = DEFAULT_DATA_WIDTH,
  parameter int MAX_PACKETS_PER_CYCLE = 8,
  parameter int CNT_WIDTH             = $clog2(MAX_PACKETS_PER_CYCLE + 1),
  localparam int IDX_W                = idxWidth(NUM_SOURCES)
) (
  input  logic                            auroraUserClk,
  input  logic                            auroraReset,
  input  logic                            auroraFAstrobe,
  input  logic                            auroraChannelUp,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SOURCES-1:0]          s_tvalid,
  input  logic [NUM_SOURCES-1:0]          s_tlast,
  output logic [NUM_SOURCES-1:0]          s_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  input  logic                            m_tready,
  output logic [IDX_W-1:0]                grantIndex,
  output logic [CNT_WIDTH-1:0]            packetCount,
  output logic                            budgetExceeded,
  output logic [ABORT_CNT_WIDTH-1:0]      abortCount
);

  txState_t               state;
  txState_t               stateNext;
  logic [IDX_W-1:0]       rrPointer;
  logic                   pickFound;
  logic [IDX_W-1:0]       pickIndex;

  logic [DATA_WIDTH-1:0]  selData;
  logic                   selValid;
  logic                   selLast;
  logic                   grantReady;

  logic [CNT_WIDTH-1:0]   effCount;
  logic                   budgetOk;
  logic                   grantNow;
  logic                   refuseNow;
  logic                   dropNow;
  logic                   discarding;
  logic                   xferDone;
  logic                   drainDone;
  logic                   packetEnd;
  logic [IDX_W-1:0]       nextPointer;

  rr_priority_picker #(
    .NUM_REQ (NUM_SOURCES)
  ) u_picker (
    .req     (s_tvalid),
    .pointer (rrPointer),
    .found   (pickFound),
    .index   (pickIndex)
  );

  // Mux the granted source; constant-index loop keeps widths exact.
  always_comb begin
    selData  = '0;
    selValid = 1'b0;
    selLast  = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (grantIndex == IDX_W'(i)) begin
        selData  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        selValid = s_tvalid[i];
        selLast  = s_tlast[i];
      end
    end
  end

  // A strobe in the same cycle makes the budget check see a fresh FA cycle.
  assign effCount  = auroraFAstrobe ? '0 : packetCount;
  assign budgetOk  = effCount < CNT_WIDTH'(MAX_PACKETS_PER_CYCLE);
  assign grantNow  = (state == IDLE) && auroraChannelUp && pickFound && budgetOk;
  assign refuseNow = (state == IDLE) && auroraChannelUp && pickFound && !budgetOk;

  // The channel-drop cycle already behaves as a drain cycle.
  assign dropNow     = (state == XFER) && !auroraChannelUp;
  assign discarding  = dropNow || (state == DRAIN);
  assign xferDone    = (state == XFER) && auroraChannelUp && selValid && selLast && m_tready;
  assign drainDone   = discarding && selValid && selLast;
  assign packetEnd   = xferDone || drainDone;
  assign nextPointer = (grantIndex == IDX_W'(NUM_SOURCES - 1)) ? '0
                                                               : grantIndex + IDX_W'(1);

  always_ff @(posedge auroraUserClk) begin
    if (auroraReset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (grantNow) stateNext = XFER;
      end
      XFER: begin
        if (dropNow) stateNext = drainDone ? IDLE : DRAIN;
        else if (xferDone) stateNext = IDLE;
      end
      DRAIN: begin
        if (drainDone) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    m_tdata    = '0;
    m_tvalid   = 1'b0;
    m_tlast    = 1'b0;
    grantReady = 1'b0;
    if ((state == XFER) && auroraChannelUp) begin
      m_tdata    = selData;
      m_tvalid   = selValid;
      m_tlast    = selLast;
      grantReady = m_tready;
    end else if (discarding) begin
      grantReady = 1'b1;
    end
  end

  always_comb begin
    s_tready = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (grantIndex == IDX_W'(i)) s_tready[i] = grantReady;
    end
  end

  always_ff @(posedge auroraUserClk) begin
    if (auroraReset) begin
      rrPointer      <= '0;
      grantIndex     <= '0;
      packetCount    <= '0;
      budgetExceeded <= 1'b0;
      abortCount     <= '0;
    end else begin
      if (grantNow) grantIndex <= pickIndex;
      if (packetEnd) rrPointer <= nextPointer;

      if (grantNow) packetCount <= effCount + CNT_WIDTH'(1);
      else if (auroraFAstrobe) packetCount <= '0;

      if (refuseNow) budgetExceeded <= 1'b1;
      else if (auroraFAstrobe) budgetExceeded <= 1'b0;

      if (dropNow) abortCount <= abortCount + ABORT_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_bpm_test_tx_arbiter.sv
// Directed bench for bpm_test_tx_arbiter: two 3-beat packet sources, budget of
// two packets per FA cycle, channel drop and reset scenarios.
module tb_bpm_test_tx_arbiter;

  localparam int NS   = 2;
  localparam int DW   = 32;
  localparam int MAXP = 2;
  localparam int CW   = $clog2(MAXP + 1);

  logic              auroraUserClk = 1'b0;
  logic              auroraReset;
  logic              auroraFAstrobe;
  logic              auroraChannelUp;
  logic [NS*DW-1:0]  s_tdata;
  logic [NS-1:0]     s_tvalid;
  logic [NS-1:0]     s_tlast;
  logic [NS-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic [0:0]        grantIndex;
  logic [CW-1:0]     packetCount;
  logic              budgetExceeded;
  logic [15:0]       abortCount;

  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [NS-1:0] srcEn;
  int          srcBeat [NS];
  int          srcPkt  [NS];
  logic [DW:0] obsQ [$];
  int          obsCyc [$];
  int          cycle = 0;
  logic [NS-1:0] seenReady;
  logic        seenValid;
  logic        randReady = 1'b0;

  always #5 auroraUserClk = ~auroraUserClk;

  bpm_test_tx_arbiter #(
    .NUM_SOURCES           (NS),
    .DATA_WIDTH            (DW),
    .MAX_PACKETS_PER_CYCLE (MAXP)
  ) dut (
    .auroraUserClk   (auroraUserClk),
    .auroraReset     (auroraReset),
    .auroraFAstrobe  (auroraFAstrobe),
    .auroraChannelUp (auroraChannelUp),
    .s_tdata         (s_tdata),
    .s_tvalid        (s_tvalid),
    .s_tlast         (s_tlast),
    .s_tready        (s_tready),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tlast         (m_tlast),
    .m_tready        (m_tready),
    .grantIndex      (grantIndex),
    .packetCount     (packetCount),
    .budgetExceeded  (budgetExceeded),
    .abortCount      (abortCount)
  );

  function automatic logic [DW-1:0] beatWord(input int src, input int pkt, input int beat);
    return DW'((src << 16) | (pkt << 8) | beat);
  endfunction

  function automatic logic [DW:0] expBeat(input int src, input int pkt, input int beat);
    return {(beat == 2), beatWord(src, pkt, beat)};
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkObs(input string tag, input int k, input logic [DW:0] exp);
    checkVal(tag, (k < obsQ.size()) ? 64'(obsQ[k]) : 64'hDEAD_BEEF_DEAD_BEEF, 64'(exp));
  endtask

  task automatic driveSources();
    for (int i = 0; i < NS; i++) begin
      s_tvalid[i]          = srcEn[i];
      s_tlast[i]           = (srcBeat[i] == 2);
      s_tdata[i*DW +: DW]  = beatWord(i, srcPkt[i], srcBeat[i]);
    end
  endtask

  task automatic resetSources(input logic clearPkt);
    for (int i = 0; i < NS; i++) begin
      srcBeat[i] = 0;
      if (clearPkt) srcPkt[i] = 0;
    end
    driveSources();
  endtask

  // One clock: sample handshakes just before the edge, advance sources after it.
  task automatic step();
    logic [NS-1:0] fire;
    #1;
    fire      = s_tvalid & s_tready;
    seenReady = seenReady | s_tready;
    seenValid = seenValid | m_tvalid;
    if (m_tvalid && m_tready) begin
      obsQ.push_back({m_tlast, m_tdata});
      obsCyc.push_back(cycle);
    end
    @(posedge auroraUserClk);
    #1;
    cycle++;
    for (int i = 0; i < NS; i++) begin
      if (fire[i]) begin
        if (srcBeat[i] == 2) begin
          srcBeat[i] = 0;
          srcPkt[i]++;
        end else begin
          srcBeat[i]++;
        end
      end
    end
    if (randReady) m_tready = 1'($urandom_range(0, 1));
    driveSources();
  endtask

  task automatic checkResetState(input string pfx);
    #1;
    checkVal({pfx, "_tvalid"}, m_tvalid, 0);
    checkVal({pfx, "_tready"}, s_tready, 0);
    checkVal({pfx, "_grant"}, grantIndex, 0);
    checkVal({pfx, "_count"}, packetCount, 0);
    checkVal({pfx, "_budget"}, budgetExceeded, 0);
    checkVal({pfx, "_abort"}, abortCount, 0);
  endtask

  initial begin
    auroraReset     = 1'b1;
    auroraFAstrobe  = 1'b0;
    auroraChannelUp = 1'b0;
    m_tready        = 1'b0;
    srcEn           = '0;
    seenReady       = '0;
    seenValid       = 1'b0;
    resetSources(1'b1);
    repeat (3) step();
    checkResetState("rst");

    // Channel down from reset, sources valid: nothing may move.
    auroraReset = 1'b0;
    srcEn       = 2'b11;
    m_tready    = 1'b1;
    driveSources();
    seenReady = '0;
    seenValid = 1'b0;
    repeat (500) step();
    checkVal("down_tvalid_seen", seenValid, 0);
    checkVal("down_tready_seen", seenReady, 0);
    checkVal("down_count", packetCount, 0);
    checkVal("down_budget", budgetExceeded, 0);

    // Source 0 alone: two packets with a one-cycle gap, then budget refusal.
    resetSources(1'b1);
    srcEn = 2'b01;
    driveSources();
    auroraChannelUp = 1'b1;
    obsQ.delete();
    obsCyc.delete();
    seenReady = '0;
    step();
    checkVal("t1_count1", packetCount, 1);
    checkVal("t1_grant0", grantIndex, 0);
    repeat (9) step();
    checkVal("t1_beats", obsQ.size(), 6);
    for (int k = 0; k < 6; k++) checkObs("t1_beat", k, expBeat(0, k / 3, k % 3));
    checkVal("t1_gap", (obsCyc.size() >= 4) ? obsCyc[3] - obsCyc[2] : -1, 2);
    checkVal("t1_ready1_seen", seenReady[1], 0);
    checkVal("t1_count2", packetCount, 2);
    checkVal("t1_budget", budgetExceeded, 1);
    #1;
    checkVal("t1_idle_tvalid", m_tvalid, 0);

    // Strobe coinciding with a grant: count 1, sticky flag cleared.
    auroraFAstrobe = 1'b1;
    step();
    auroraFAstrobe = 1'b0;
    checkVal("t3_strobe_grant_count", packetCount, 1);
    checkVal("t3_strobe_budget", budgetExceeded, 0);
    #1;
    checkVal("t3_xfer_tvalid", m_tvalid, 1);
    repeat (3) step();
    srcEn = 2'b00;
    driveSources();
    auroraFAstrobe = 1'b1;
    step();
    auroraFAstrobe = 1'b0;
    checkVal("t3_strobe_clear", packetCount, 0);

    // Packet in flight across a strobe is not recounted.
    srcEn = 2'b01;
    driveSources();
    step();
    auroraFAstrobe = 1'b1;
    step();
    auroraFAstrobe = 1'b0;
    step();
    step();
    checkVal("t3_inflight_count", packetCount, 0);
    srcEn = 2'b00;
    driveSources();
    step();

    // Fresh pointer, both sources valid, random sink backpressure.
    auroraReset = 1'b1;
    repeat (2) step();
    auroraReset = 1'b0;
    resetSources(1'b1);
    obsQ.delete();
    srcEn     = 2'b11;
    randReady = 1'b1;
    driveSources();
    for (int n = 0; n < 200 && obsQ.size() < 6; n++) step();
    repeat (3) step();
    checkVal("t2_first_pair", obsQ.size(), 6);
    checkVal("t2_budget", budgetExceeded, 1);
    checkVal("t2_count", packetCount, 2);
    auroraFAstrobe = 1'b1;
    step();
    auroraFAstrobe = 1'b0;
    checkVal("t2_strobe_count", packetCount, 1);
    for (int n = 0; n < 200 && obsQ.size() < 12; n++) step();
    checkVal("t2_done", obsQ.size(), 12);
    for (int k = 0; k < 12; k++) checkObs("t2_beat", k, expBeat((k / 3) % 2, k / 6, k % 3));
    randReady = 1'b0;
    m_tready  = 1'b1;
    step();

    // Channel drops on the second beat of source 0's packet.
    obsQ.delete();
    auroraFAstrobe = 1'b1;
    step();
    auroraFAstrobe = 1'b0;
    checkVal("t4_grant0", grantIndex, 0);
    step();
    auroraChannelUp = 1'b0;
    #1;
    checkVal("t4_drop_tvalid", m_tvalid, 0);
    checkVal("t4_drop_tready", s_tready, 2'b01);
    step();
    checkVal("t4_abort", abortCount, 1);
    #1;
    checkVal("t4_drain_tready", s_tready, 2'b01);
    checkVal("t4_drain_tvalid", m_tvalid, 0);
    step();
    checkVal("t4_drained_pkt", srcPkt[0], 3);
    checkVal("t4_drained_beat", srcBeat[0], 0);
    seenReady = '0;
    seenValid = 1'b0;
    repeat (5) step();
    checkVal("t4_down_tvalid", seenValid, 0);
    checkVal("t4_down_tready", seenReady, 0);
    checkVal("t4_down_count", packetCount, 1);
    auroraChannelUp = 1'b1;
    driveSources();
    step();
    checkVal("t4_resume_grant", grantIndex, 1);
    step();
    checkVal("t4_resume_beats", obsQ.size(), 2);
    checkObs("t4_resume_beat", 1, expBeat(1, 2, 0));

    // Reset in the middle of source 1's packet.
    auroraReset = 1'b1;
    step();
    checkResetState("t5");
    auroraReset = 1'b0;
    resetSources(1'b0);
    obsQ.delete();
    step();
    checkVal("t5_ptr_grant", grantIndex, 0);
    step();
    checkObs("t5_first_beat", 0, expBeat(0, 3, 0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
